// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link.
// SERIAL_TX_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package serial_pkg;

  localparam int unsigned NbitsDataDefault = 4;

  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_t;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_t;
`endif

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake into the serial transmitter: producer is master, transmitter is slave.
interface serial_tx_if #(
  parameter int unsigned NBITS_DATA = serial_pkg::NbitsDataDefault
);
  logic [NBITS_DATA-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/serial_bit_timer.sv
// Per-bit down-counter; bit_end marks the last cycle of each line bit.
module serial_bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk_2,
  input  logic reset,
  input  logic load,
  output logic bit_end
);
  localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);
  localparam logic [CntW-1:0] Reload = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CntW'(1);
    if (load || bit_end) cnt_d = Reload;
  end

  always_ff @(posedge clk_2) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_tx.sv
// LSB-first frame transmitter: start, data, optional even parity, stop.
// Define SERIAL_TX_PARITY_EN to insert the parity bit after the data bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned NBITS_DATA = NbitsDataDefault,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                            clk_2,
  input  logic                            reset,
  serial_tx_if.slave                      tx_if,
  output logic                            serial_out,
  output logic                            busy,
  output logic [$clog2(NBITS_DATA+1)-1:0] bit_idx,
  output logic                            frame_done
);
  localparam int unsigned IdxW = $clog2(NBITS_DATA + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBITS_DATA - 1);

  tx_state_t             state_q, state_d;
  logic [NBITS_DATA-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic                  accept, bit_end, last_bit, data_bit_end;

  assign accept       = (state_q == StIdle) && tx_if.valid_in;
  assign last_bit     = (bit_idx_q == LastIdx);
  assign data_bit_end = (state_q == StData) && bit_end;

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_2  (clk_2),
    .reset  (reset),
    .load   (accept),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk_2) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end && last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: if (bit_end) state_d = StStop;
`endif
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (accept) begin
      shift_d = tx_if.data_in;
    end else if (data_bit_end) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = last_bit ? '0 : bit_idx_q + IdxW'(1);
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;

  // Accumulates each bit as it leaves the line, so it is complete when DATA ends.
  always_comb begin
    parity_d = parity_q;
    if (accept)            parity_d = 1'b0;
    else if (data_bit_end) parity_d = parity_q ^ shift_q[0];
  end

  always_ff @(posedge clk_2) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    serial_out = LineIdle;
    unique case (state_q)
      StIdle:   serial_out = LineIdle;
      StStart:  serial_out = LineStart;
      StData:   serial_out = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: serial_out = parity_q;
`endif
      StStop:   serial_out = LineStop;
      default:  serial_out = LineIdle;
    endcase
    tx_if.ready_out = (state_q == StIdle);
    busy            = (state_q != StIdle);
    frame_done      = (state_q == StStop) && bit_end;
    bit_idx         = bit_idx_q;
  end
endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench: two transmitters (BIT_CYCLES 2 and 1) checked cycle by cycle.
module tb_serial_tx;
  localparam int NB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  typedef struct packed {
    logic       so;
    logic       busy;
    logic       rdy;
    logic       done;
    logic [2:0] idx;
  } exp_t;

  localparam exp_t IdleExp = '{so: 1'b1, busy: 1'b0, rdy: 1'b1, done: 1'b0, idx: 3'd0};

  logic clk_2 = 1'b0;
  logic reset;
  always #5 clk_2 = ~clk_2;

  serial_tx_if #(.NBITS_DATA(NB)) if_a ();
  serial_tx_if #(.NBITS_DATA(NB)) if_b ();

  logic       so_a, busy_a, done_a, so_b, busy_b, done_b;
  logic [2:0] idx_a, idx_b;

  serial_tx #(.NBITS_DATA(NB), .BIT_CYCLES(2)) dut_a (
    .clk_2(clk_2), .reset(reset), .tx_if(if_a), .serial_out(so_a), .busy(busy_a),
    .bit_idx(idx_a), .frame_done(done_a)
  );

  serial_tx #(.NBITS_DATA(NB), .BIT_CYCLES(1)) dut_b (
    .clk_2(clk_2), .reset(reset), .tx_if(if_b), .serial_out(so_b), .busy(busy_b),
    .bit_idx(idx_b), .frame_done(done_b)
  );

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int bc_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int flen(input int d);
    return (NB + 2 + Par) * bc_of(d);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cmp(input int d, input exp_t e, input string tag);
    exp_t o;
    if (d == 0) o = '{so: so_a, busy: busy_a, rdy: if_a.ready_out, done: done_a, idx: idx_a};
    else        o = '{so: so_b, busy: busy_b, rdy: if_b.ready_out, done: done_b, idx: idx_b};
    check($sformatf("%s[%0d].serial_out", tag, d), 8'(o.so), 8'(e.so));
    check($sformatf("%s[%0d].busy", tag, d), 8'(o.busy), 8'(e.busy));
    check($sformatf("%s[%0d].ready_out", tag, d), 8'(o.rdy), 8'(e.rdy));
    check($sformatf("%s[%0d].frame_done", tag, d), 8'(o.done), 8'(e.done));
    check($sformatf("%s[%0d].bit_idx", tag, d), 8'(o.idx), 8'(e.idx));
  endtask

  task automatic drive(input int d, input logic v, input logic [3:0] w);
    if (d == 0) begin
      if_a.valid_in = v;
      if_a.data_in  = w;
    end else begin
      if_b.valid_in = v;
      if_b.data_in  = w;
    end
  endtask

  function automatic void push_bit(input int bc, input logic lvl, input logic [2:0] idx,
                                   input logic last);
    for (int c = 0; c < bc; c++)
      exp_q.push_back('{so: lvl, busy: 1'b1, rdy: 1'b0, done: last && (c == bc - 1), idx: idx});
  endfunction

  function automatic void push_frame(input int d, input logic [3:0] w);
    int bc = bc_of(d);
    push_bit(bc, 1'b0, 3'd0, 1'b0);
    for (int j = 0; j < NB; j++) push_bit(bc, w[j], 3'(j), 1'b0);
    if (Par != 0) push_bit(bc, ^w, 3'd0, 1'b0);
    push_bit(bc, 1'b1, 3'd0, 1'b1);
  endfunction

  // Compares up to maxn queued cycles; from entry vstop on, valid_in is held low.
  task automatic drain(input int d, input int maxn, input bit noise, input int vstop,
                       input string tag);
    int i = 0;
    while (exp_q.size() > 0 && i < maxn) begin
      cmp(d, exp_q.pop_front(), tag);
      if (i >= vstop)  drive(d, 1'b0, 4'h0);
      else if (noise) drive(d, 1'($urandom), 4'($urandom));
      @(negedge clk_2);
      i++;
    end
  endtask

  task automatic send(input int d, input logic [3:0] w, input bit noise, input string tag);
    drive(d, 1'b1, w);
    @(negedge clk_2);
    drive(d, 1'b0, w);
    push_frame(d, w);
    exp_q.push_back(IdleExp);
    drain(d, flen(d) + 1, noise, flen(d), tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    repeat (2) @(negedge clk_2);
    cmp(0, IdleExp, "reset");
    cmp(1, IdleExp, "reset");
    reset = 1'b0;

    repeat (10) begin
      @(negedge clk_2);
      cmp(0, IdleExp, "idle");
      cmp(1, IdleExp, "idle");
    end

    send(0, 4'b1011, 1'b0, "bc2_1011");
    send(1, 4'b1011, 1'b0, "bc1_1011");
    send(1, 4'b0011, 1'b0, "bc1_0011");
    send(1, 4'h6, 1'b1, "busy_noise");
    send(0, 4'h9, 1'b1, "busy_noise");

    // Back-to-back: valid_in held through the single IDLE cycle between frames.
    drive(1, 1'b1, 4'hA);
    @(negedge clk_2);
    drive(1, 1'b1, 4'h5);
    push_frame(1, 4'hA);
    exp_q.push_back(IdleExp);
    push_frame(1, 4'h5);
    exp_q.push_back(IdleExp);
    drain(1, 2 * flen(1) + 2, 1'b0, flen(1) + 1, "b2b");

    // Abort: reset sampled at the end of cycle k+3.
    drive(1, 1'b1, 4'hC);
    @(negedge clk_2);
    drive(1, 1'b0, 4'h0);
    push_frame(1, 4'hC);
    drain(1, 2, 1'b0, 99, "abort");
    cmp(1, exp_q.pop_front(), "abort");
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) begin
      cmp(1, IdleExp, "abort_idle");
      @(negedge clk_2);
    end
    send(1, 4'h3, 1'b0, "after_abort");

    // Reset and valid_in together: nothing is accepted.
    drive(1, 1'b1, 4'hF);
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    drive(1, 1'b0, 4'h0);
    cmp(1, IdleExp, "rst_valid");
    @(negedge clk_2);
    cmp(1, IdleExp, "rst_valid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
